// File: rtl/sc_aux_downcounter.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and optional auto-reload.
// Load is visible one cycle after the strobe edge; tc rises the cycle after count==1 is consumed.
module sc_aux_downcounter #(
  parameter int auxDOWNCOUNTER_DATAWIDTH = 8
) (
  input  logic                                SC_auxDOWNCOUNTER_CLOCK_50,
  input  logic                                SC_auxDOWNCOUNTER_RESET_InLow,
  input  logic                                SC_auxDOWNCOUNTER_load_InLow,
  input  logic [auxDOWNCOUNTER_DATAWIDTH-1:0] SC_auxDOWNCOUNTER_data_InBUS,
  input  logic                                SC_auxDOWNCOUNTER_downcount_InLow,
  input  logic                                SC_auxDOWNCOUNTER_autoreload_InHigh,
  output logic [auxDOWNCOUNTER_DATAWIDTH-1:0] SC_auxDOWNCOUNTER_data_OutBUS,
  output logic                                SC_auxDOWNCOUNTER_tc_OutHigh,
  output logic                                SC_auxDOWNCOUNTER_busy_OutHigh,
  output logic                                SC_auxDOWNCOUNTER_zero_OutHigh
);

  localparam int W = auxDOWNCOUNTER_DATAWIDTH;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           tc_q, tc_d;

  always_ff @(posedge SC_auxDOWNCOUNTER_CLOCK_50) begin
    if (!SC_auxDOWNCOUNTER_RESET_InLow) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (!SC_auxDOWNCOUNTER_load_InLow) begin
      // Load beats any same-edge decrement or terminal count.
      count_d  = SC_auxDOWNCOUNTER_data_InBUS;
      reload_d = SC_auxDOWNCOUNTER_data_InBUS;
      state_d  = (SC_auxDOWNCOUNTER_data_InBUS != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (!SC_auxDOWNCOUNTER_downcount_InLow) begin
            if (count_q == ONE) begin
              tc_d = 1'b1;
              if (SC_auxDOWNCOUNTER_autoreload_InHigh) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = EXPIRED;
              end
            end else begin
              count_d = count_q - ONE;
            end
          end
        end
        IDLE, EXPIRED: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign SC_auxDOWNCOUNTER_data_OutBUS  = count_q;
  assign SC_auxDOWNCOUNTER_tc_OutHigh   = tc_q;
  assign SC_auxDOWNCOUNTER_busy_OutHigh = (state_q == RUN);
  assign SC_auxDOWNCOUNTER_zero_OutHigh = (count_q == '0);

endmodule

// File: tb/tb_sc_aux_downcounter.sv
// Directed bench for sc_aux_downcounter; expected values are hand-computed per step.
module tb_sc_aux_downcounter;

  logic       clk;
  logic       rst_n;
  logic       load_n;
  logic [7:0] din;
  logic       down_n;
  logic       ar;
  logic [7:0] dout;
  logic       tc;
  logic       busy;
  logic       zero;

  int total = 0;
  int bad   = 0;

  sc_aux_downcounter #(.auxDOWNCOUNTER_DATAWIDTH(8)) dut (
    .SC_auxDOWNCOUNTER_CLOCK_50         (clk),
    .SC_auxDOWNCOUNTER_RESET_InLow      (rst_n),
    .SC_auxDOWNCOUNTER_load_InLow       (load_n),
    .SC_auxDOWNCOUNTER_data_InBUS       (din),
    .SC_auxDOWNCOUNTER_downcount_InLow  (down_n),
    .SC_auxDOWNCOUNTER_autoreload_InHigh(ar),
    .SC_auxDOWNCOUNTER_data_OutBUS      (dout),
    .SC_auxDOWNCOUNTER_tc_OutHigh       (tc),
    .SC_auxDOWNCOUNTER_busy_OutHigh     (busy),
    .SC_auxDOWNCOUNTER_zero_OutHigh     (zero)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Checks the full observable state after the most recent edge.
  task automatic chk_all(input string tag, input logic [7:0] d, input logic t, input logic b);
    chk8({tag, ".data"}, dout, d);
    chk1({tag, ".tc"}, tc, t);
    chk1({tag, ".busy"}, busy, b);
    chk1({tag, ".zero"}, zero, (d == 8'd0));
  endtask

  task automatic do_load(input logic [7:0] v);
    load_n = 1'b0;
    din    = v;
    tick();
    load_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int left;
    logic [7:0] exp_d;
    logic exp_t;

    rst_n = 1'b0; load_n = 1'b1; din = 8'd0; down_n = 1'b1; ar = 1'b0;

    // Reset
    tick(); tick();
    chk_all("reset", 8'd0, 1'b0, 1'b0);
    rst_n  = 1'b1;
    down_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("idle_dec", 8'd0, 1'b0, 1'b0);
      down_n = ~down_n;
    end

    // One-shot: load wins over a simultaneous enable
    down_n = 1'b0; ar = 1'b0;
    do_load(8'd3);
    chk_all("os_load", 8'd3, 1'b0, 1'b1);
    tick(); chk_all("os_2", 8'd2, 1'b0, 1'b1);
    tick(); chk_all("os_1", 8'd1, 1'b0, 1'b1);
    tick(); chk_all("os_0", 8'd0, 1'b1, 1'b0);
    tick(); chk_all("os_hold0", 8'd0, 1'b0, 1'b0);
    tick(); chk_all("os_hold1", 8'd0, 1'b0, 1'b0);

    // Autoreload period 4
    ar = 1'b1; down_n = 1'b0;
    do_load(8'd4);
    chk_all("ar_load", 8'd4, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_d = 8'(4 - (i % 4));
      exp_t = (i % 4 == 0);
      if (tc) pulses++;
      chk_all("ar_run", exp_d, exp_t, 1'b1);
    end
    total++;
    assert (pulses === 3) else begin
      bad++;
      $error("FAIL ar_pulses observed=%0d expected=3", pulses);
    end

    // Gated enable: only even steps enabled
    ar = 1'b0; down_n = 1'b1;
    do_load(8'd5);
    chk_all("gate_load", 8'd5, 1'b0, 1'b1);
    left = 5;
    for (int i = 0; i < 10; i++) begin
      down_n = (i % 2 == 1);
      exp_t  = 1'b0;
      if (!down_n && left > 0) begin
        left--;
        exp_t = (left == 0);
      end
      tick();
      chk_all("gate", 8'(left), exp_t, (left != 0));
    end

    // Load collides with terminal count
    down_n = 1'b1;
    do_load(8'd2);
    down_n = 1'b0;
    tick(); chk_all("col_1", 8'd1, 1'b0, 1'b1);
    do_load(8'd9);
    chk_all("col_load9", 8'd9, 1'b0, 1'b1);
    do_load(8'd0);
    chk_all("col_load0", 8'd0, 1'b0, 1'b0);
    tick(); chk_all("col_idle", 8'd0, 1'b0, 1'b0);

    // Autoreload sampled only at the terminal-count edge
    ar = 1'b0; down_n = 1'b1;
    do_load(8'd2);
    ar = 1'b1; down_n = 1'b0;
    tick(); chk_all("arsamp_1", 8'd1, 1'b0, 1'b1);
    ar = 1'b0;
    tick(); chk_all("arsamp_exp", 8'd0, 1'b1, 1'b0);

    // Reset mid-run
    down_n = 1'b1;
    do_load(8'd200);
    down_n = 1'b0;
    repeat (50) tick();
    chk_all("mid_150", 8'd150, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all("mid_rst", 8'd0, 1'b0, 1'b0);
    down_n = 1'b1;
    do_load(8'd2);
    chk_all("post_2", 8'd2, 1'b0, 1'b1);
    down_n = 1'b0;
    tick(); chk_all("post_1", 8'd1, 1'b0, 1'b1);
    tick(); chk_all("post_0", 8'd0, 1'b1, 1'b0);

    // Reset on the terminal-count edge suppresses tc
    down_n = 1'b1;
    do_load(8'd1);
    down_n = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all("rst_tc", 8'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
